// File: rtl/ped_walk_if.sv
// Pedestrian arbiter bus: raw requests and permissive mask in, lamps and status out.
interface ped_walk_if #(
    parameter int unsigned NUM_REQ = 8
);
    logic [NUM_REQ-1:0] ped_button;
    logic [NUM_REQ-1:0] walk_ok;
    logic [NUM_REQ-1:0] walk;
    logic [NUM_REQ-1:0] flash_dont_walk;
    logic [NUM_REQ-1:0] pending;
    logic               phase_hold;
    logic               busy;

    modport master (
        output ped_button, walk_ok,
        input  walk, flash_dont_walk, pending, phase_hold, busy
    );

    modport slave (
        input  ped_button, walk_ok,
        output walk, flash_dont_walk, pending, phase_hold, busy
    );
endinterface

// File: rtl/ped_walk_arbiter.sv
// Round-robin pedestrian walk scheduler with walk/clearance lamp timing.
// Optional PED_ABORT_REQUEUE_EN: an aborted walk re-queues its request.
module ped_walk_arbiter #(
    parameter int unsigned NUM_REQ      = 8,
    parameter int unsigned WALK_CYCLES  = 6,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic      clock,
    input  logic      reset_n,
    ped_walk_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] btn_q;
    logic               arm_q;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] walk_q, walk_d;
    logic [NUM_REQ-1:0] flash_q, flash_d;
    logic               phase_hold_q, phase_hold_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [NUM_REQ-1:0] req_edge_c, elig_c, clr_c, requeue_c;
    logic [PTR_W-1:0]   pick_c, idx_c;
    logic               found_c;

    // Buttons already high when reset releases are absorbed by the first clock.
    assign req_edge_c = arm_q ? (bus.ped_button & ~btn_q) : '0;
    assign elig_c     = pending_q & bus.walk_ok;

    // First eligible crosswalk at or after rr_ptr, wrapping.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_c = PTR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!found_c && elig_c[idx_c]) begin
                found_c = 1'b1;
                pick_c  = idx_c;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        clr_c     = '0;
        requeue_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_d       = ST_WALK;
                    sel_d         = pick_c;
                    cnt_d         = 8'(WALK_CYCLES - 1);
                    rr_ptr_d      = PTR_W'((32'(pick_c) + 32'd1) % NUM_REQ);
                    clr_c[pick_c] = 1'b1;
                end
            end
            ST_WALK: begin
                if (!bus.walk_ok[sel_q]) begin
                    state_d = ST_CLEAR;
                    cnt_d   = 8'(CLEAR_CYCLES - 1);
`ifdef PED_ABORT_REQUEUE_EN
                    requeue_c[sel_q] = 1'b1;
`else
                    requeue_c = '0;
`endif
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_CLEAR;
                    cnt_d   = 8'(CLEAR_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // New edges win over the grant clear on the same bit.
        pending_d    = (pending_q & ~clr_c) | req_edge_c | requeue_c;
        walk_d       = (state_d == ST_WALK)  ? (NUM_REQ'(1) << sel_d) : '0;
        flash_d      = (state_d == ST_CLEAR) ? (NUM_REQ'(1) << sel_d) : '0;
        phase_hold_d = (state_d == ST_WALK) || (state_d == ST_CLEAR);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            btn_q        <= '0;
            arm_q        <= 1'b0;
            pending_q    <= '0;
            walk_q       <= '0;
            flash_q      <= '0;
            phase_hold_q <= 1'b0;
            busy_q       <= 1'b0;
            rr_ptr_q     <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            btn_q        <= bus.ped_button;
            arm_q        <= 1'b1;
            pending_q    <= pending_d;
            walk_q       <= walk_d;
            flash_q      <= flash_d;
            phase_hold_q <= phase_hold_d;
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.walk            = walk_q;
    assign bus.flash_dont_walk = flash_q;
    assign bus.pending         = pending_q;
    assign bus.phase_hold      = phase_hold_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_ped_walk_arbiter.sv
// Directed scoreboard bench for ped_walk_arbiter (NUM_REQ=8, WALK=6, CLEAR=2).
module tb_ped_walk_arbiter;
    localparam int unsigned N = 8;
`ifdef PED_ABORT_REQUEUE_EN
    localparam logic [7:0] ABORT_PEND = 8'h04;
`else
    localparam logic [7:0] ABORT_PEND = 8'h00;
`endif

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    ped_walk_if #(.NUM_REQ(N)) bus ();

    ped_walk_arbiter #(
        .NUM_REQ(N), .WALK_CYCLES(6), .CLEAR_CYCLES(2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [7:0] walk;
        logic [7:0] flash;
        logic [7:0] pend;
        logic       ph;
        logic       busy;
    } obs_t;

    obs_t  sb_q[$];
    string tag_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    task automatic push(input string tag, input logic [7:0] w, input logic [7:0] f,
                        input logic [7:0] p, input logic ph, input logic b);
        obs_t e;
        e.walk = w; e.flash = f; e.pend = p; e.ph = ph; e.busy = b;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        obs_t  e, o;
        string t;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            o.walk = bus.walk; o.flash = bus.flash_dont_walk; o.pend = bus.pending;
            o.ph = bus.phase_hold; o.busy = bus.busy;
            compared++;
            assert (o === e) else begin
                mismatched++;
                $error("FAIL %s: observed walk=%h flash=%h pend=%h hold=%b busy=%b, expected walk=%h flash=%h pend=%h hold=%b busy=%b",
                       t, o.walk, o.flash, o.pend, o.ph, o.busy, e.walk, e.flash, e.pend, e.ph, e.busy);
            end
        end
    endtask

    task automatic step(input string tag, input logic [7:0] w, input logic [7:0] f,
                        input logic [7:0] p, input logic ph, input logic b);
        push(tag, w, f, p, ph, b);
        @(posedge clock);
        @(negedge clock);
        drain();
    endtask

    task automatic check_now(input string tag, input logic [7:0] w, input logic [7:0] f,
                             input logic [7:0] p, input logic ph, input logic b);
        push(tag, w, f, p, ph, b);
        drain();
    endtask

    task automatic serve(input string tag, input logic [7:0] oh, input logic [7:0] pend_first,
                         input logic [7:0] pend_rest, input logic [7:0] btn_after);
        step(tag, oh, 8'h00, pend_first, 1'b1, 1'b1);
        bus.ped_button = btn_after;
        repeat (5) step(tag, oh, 8'h00, pend_rest, 1'b1, 1'b1);
        repeat (2) step(tag, 8'h00, oh, pend_rest, 1'b1, 1'b1);
        step(tag, 8'h00, 8'h00, pend_rest, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input logic [7:0] btn);
        reset_n        = 1'b0;
        bus.ped_button = btn;
        bus.walk_ok    = 8'h00;
        #1;
        check_now("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        step("reset_arm", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.ped_button = 8'hFF;
        bus.walk_ok    = 8'h00;
        #3;
        check_now("reset_ff", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Buttons held high through reset release never register.
        bus.walk_ok = 8'hFF;
        repeat (3) step("btn_held", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.ped_button = 8'h00;
        step("btn_fall", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Single request on crosswalk 2.
        bus.walk_ok    = 8'h04;
        bus.ped_button = 8'h04;
        step("single_latch", 8'h00, 8'h00, 8'h04, 1'b0, 1'b0);
        serve("single", 8'h04, 8'h00, 8'h00, 8'h04);
        step("single_idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step("single_held", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Round-robin with wrap.
        do_reset(8'h00);
        bus.ped_button = 8'h81;
        step("rr_latch", 8'h00, 8'h00, 8'h81, 1'b0, 1'b0);
        bus.walk_ok = 8'hFF;
        serve("rr_b0", 8'h01, 8'h80, 8'h80, 8'h80);
        step("rr_idle0", 8'h00, 8'h00, 8'h80, 1'b0, 1'b0);
        serve("rr_b7", 8'h80, 8'h00, 8'h03, 8'h83);
        step("rr_idle7", 8'h00, 8'h00, 8'h03, 1'b0, 1'b0);
        serve("rr_wrap_b0", 8'h01, 8'h02, 8'h02, 8'h83);
        step("rr_idle_w", 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
        serve("rr_b1", 8'h02, 8'h00, 8'h00, 8'h83);

        // Abort on the third walk clock.
        do_reset(8'h00);
        bus.walk_ok    = 8'h04;
        bus.ped_button = 8'h04;
        step("ab_latch", 8'h00, 8'h00, 8'h04, 1'b0, 1'b0);
        repeat (3) step("ab_walk", 8'h04, 8'h00, 8'h00, 1'b1, 1'b1);
        bus.walk_ok = 8'h00;
        repeat (2) step("ab_flash", 8'h00, 8'h04, ABORT_PEND, 1'b1, 1'b1);
        step("ab_gap", 8'h00, 8'h00, ABORT_PEND, 1'b0, 1'b1);
        step("ab_idle", 8'h00, 8'h00, ABORT_PEND, 1'b0, 1'b0);

        // Non-permissive hold, then walk one clock after permission.
        do_reset(8'h00);
        bus.ped_button = 8'h10;
        step("np_latch", 8'h00, 8'h00, 8'h10, 1'b0, 1'b0);
        repeat (20) step("np_hold", 8'h00, 8'h00, 8'h10, 1'b0, 1'b0);
        bus.walk_ok = 8'h10;
        step("np_walk", 8'h10, 8'h00, 8'h00, 1'b1, 1'b1);
        bus.ped_button = 8'h30;
        step("np_walk2", 8'h10, 8'h00, 8'h20, 1'b1, 1'b1);

        // Asynchronous reset mid-walk.
        #2;
        reset_n = 1'b0;
        #1;
        check_now("async_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        step("post_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ped_walk_arbiter.md
# ped_walk_arbiter

Pedestrian crossing scheduler for the intersection signal controller. It latches push-button requests from NUM_REQ crosswalks and grants one walk interval at a time, round-robin, only while the phase controller reports that crossing as permissive. It holds the vehicle phase counter during walk and clearance. It sits between the raw pedestrian inputs and the phase/lamp FSM, and owns all walk and don't-walk lamp timing.

## Interface

Parameters:
- NUM_REQ, 8: number of crosswalks (north, south, east, west, and their _one counterparts); legal range 2..16.
- WALK_CYCLES, 6: walk lamp duration in clocks; legal range 1..255.
- CLEAR_CYCLES, 2: flashing don't-walk duration in clocks; legal range 1..255.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- ped_button  in  NUM_REQ  raw request level per crosswalk; rising edge = new request.
- walk_ok  in  NUM_REQ  from phase FSM; bit i high when crosswalk i is permitted (conflicting approach red, parallel approach green).
- walk  out  NUM_REQ  walk lamp; one-hot or zero.
- flash_dont_walk  out  NUM_REQ  clearance lamp; one-hot or zero.
- pending  out  NUM_REQ  latched, unserved requests.
- phase_hold  out  1  high in WALK and CLEAR; the phase FSM freezes its counters while high.
- busy  out  1  high whenever state is not IDLE.

## Operation

- Edge detect: btn_q registers ped_button. A request edge is ped_button[i] & ~btn_q[i].
- Request latch: pending[i] sets on a request edge and clears on the clock that enters WALK for i. If a set and a clear hit the same bit on the same clock, the set wins, so the request is re-queued.
- Eligibility: elig = pending & walk_ok, evaluated only in IDLE.
- Arbitration: rr_ptr (clog2(NUM_REQ) bits) selects the first set bit of elig, scanning rr_ptr, rr_ptr+1, and so on, wrapping modulo NUM_REQ. On grant, rr_ptr becomes (sel+1) mod NUM_REQ. rr_ptr is unchanged otherwise.
- FSM states: IDLE, WALK, CLEAR, GAP.
  - IDLE -> WALK when elig != 0. Latch sel; cnt loads WALK_CYCLES-1.
  - WALK: walk[sel]=1. The clock where cnt==0 goes to CLEAR and loads cnt with CLEAR_CYCLES-1. If walk_ok[sel] is sampled low, go to CLEAR immediately (abort), regardless of cnt.
  - CLEAR: flash_dont_walk[sel]=1. The clock where cnt==0 goes to GAP. walk_ok changes are ignored in CLEAR.
  - GAP: one clock with all lamps off, then IDLE. This guarantees one dead cycle between services.
- cnt is 8 bits, decrements by 1 per clock in WALK and CLEAR, and never wraps below 0.
- All outputs are registered. walk and flash_dont_walk are never high in the same cycle.
- Requests arriving for other crosswalks during WALK/CLEAR/GAP latch normally and compete at the next IDLE.

## Timing

- Reset values (reset_n low, async): state=IDLE, walk=0, flash_dont_walk=0, pending=0, phase_hold=0, busy=0, rr_ptr=0, btn_q=0, cnt=0.
- Reset mid-service drops all lamps and all pending requests immediately. No clearance interval is produced.
- Latency, ped_button rising (sampled at edge t) to pending high: visible after edge t.
- Latency to walk high: visible after edge t+1, provided walk_ok is high and no higher-priority grant wins.
- Walk is high for exactly WALK_CYCLES clocks, unless aborted. Flashing don't-walk is high for exactly CLEAR_CYCLES clocks.
- Abort: walk_ok[sel] sampled low at edge a puts flash_dont_walk[sel] high after edge a, with walk low in the same cycle.
- phase_hold and busy rise with walk. phase_hold falls on entry to GAP; busy falls on entry to IDLE.
- A held-high ped_button produces only one request.

## Configuration

- PED_ABORT_REQUEUE_EN defined: an aborted walk re-sets pending[sel] on the abort clock, so the crosswalk is served again at its next permissive window.
- PED_ABORT_REQUEUE_EN undefined: an aborted walk consumes the request; pending[sel] stays 0 unless a new edge arrives.

## Test plan

- Reset with ped_button=8'hFF held. Release reset_n with buttons already high. Required: no pending set until a button falls and rises again; all outputs 0.
- Single request: edge on bit 2, walk_ok=8'h04. Required: pending=8'h04 for 1 clock; walk=8'h04 for 6 clocks; flash_dont_walk=8'h04 for 2 clocks; 1 GAP clock; phase_hold high for 8 clocks.
- Round-robin: pending=8'h81, walk_ok=8'hFF, rr_ptr=0. Required: bit 0 served first, then bit 7; next the pointer wraps so bit 0 wins over bit 1.
- Abort: walk_ok[2] drops on the 3rd walk clock. Required: walk lasts 3 clocks, then flash 2 clocks. pending[2]=1 afterward when PED_ABORT_REQUEUE_EN is defined, 0 when it is not.
- Non-permissive hold: pending=8'h10, walk_ok=0 for 20 clocks, then walk_ok=8'h10. Required: no walk during the 20 clocks; walk[4] rises 1 clock after walk_ok rises.
- Async reset mid-WALK: reset_n low mid-cycle. Required: walk, pending and phase_hold go to 0 without waiting for a clock edge.
